ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-master arbiter and sequencer for the single-port system RAM (16-bit address and data, 1-bit byte-enable).
- Master 0 is the CPU memory port; master 1 is a secondary bus master (DMA / UART loader).
- Serialises accesses, drives the RAM control signals and returns read data with a one-cycle ack pulse.
- M0 has priority; a bounded-hold counter guarantees M1 forward progress.

Parameters:
- RD_LAT, 1: RAM read latency in cycles, from the issue cycle to ram_dout valid. Legal range 1..4.
- MAX_HOLD, 4: maximum consecutive M0 grants while m1_req is pending. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- m0_req  in  1  M0 request; held high with fields stable until m0_ack
- m0_we  in  1  M0 write (1) / read (0)
- m0_be  in  1  M0 byte-enable
- m0_addr  in  16  M0 address
- m0_wdata  in  16  M0 write data
- m0_ack  out  1  M0 completion pulse
- m0_rdata  out  16  M0 read data
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_ack, m1_rdata: same as M0, for M1
- ram_addr  out  16  RAM address
- ram_din  out  16  RAM write data
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe
- ram_be  out  1  RAM byte-enable
- ram_dout  in  16  RAM read data
- owner  out  2  00 none, 01 M0, 10 M1; valid from ISSUE through ACK

Behaviour:
- Reset (clk edge with reset=1):
  - state = IDLE; owner = 0; hold_cnt = 0; lat_cnt = 0.
  - All acks and all ram_* outputs = 0; m0_rdata = m1_rdata = 0.
  - Reset mid-transaction aborts it: no ack is issued, and no RAM strobe occurs in the cycle after reset.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req is high: pick the winner, latch its we/be/addr/wdata and owner, then go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration (evaluated only in IDLE):
  - Only m0_req high: grant M0.
  - Only m1_req high: grant M1.
  - Both high: grant M1 if hold_cnt == MAX_HOLD, else grant M0.
- hold_cnt update:
  - Increments (saturating at MAX_HOLD) on an M0 grant while m1_req = 1.
  - Clears on any M1 grant, and on an M0 grant while m1_req = 0.
- ISSUE (exactly 1 cycle):
  - ram_addr/ram_be/ram_din driven from the latched fields.
  - ram_we = latched we; ram_re = !latched we.
  - Write: go to ACK.
  - Read: load lat_cnt = RD_LAT-1 and go to WAIT.
- WAIT:
  - If lat_cnt == 0: register ram_dout into the owner's rdata and go to ACK.
  - Otherwise decrement lat_cnt.
  - ram_we = ram_re = 0.
- ACK (1 cycle):
  - Owner's ack = 1; go to IDLE unconditionally.
  - req is ignored in ACK; a master may hold req high into the next cycle to start a new access.
- Latency from the first IDLE cycle with req high to ack:
  - Write: 2 cycles (ISSUE, then ACK).
  - Read: RD_LAT+2 cycles.
- Outside ISSUE, ram_addr/ram_din/ram_be hold the latched values; ram_we and ram_re are 0.
- rdata behaviour:
  - Each master's rdata holds its value until that master's next read completes.
  - Writes never alter rdata.
  - The non-owner's rdata is never disturbed.
- A master deasserting req before its ack is a protocol violation; the arbiter completes the latched access anyway.
- Never more than one ack high; never ram_we and ram_re high together.

Test Plan:
- Reset, then M0 write addr 0x0010 data 0xBEEF → ram_we=1 exactly one cycle with ram_addr=0x0010, ram_din=0xBEEF; m0_ack two cycles after req; owner=01 during ISSUE through ACK.
- RAM model with RD_LAT=1 holding 0x1234 at 0x0020; M1 reads 0x0020 → ram_re one cycle; m1_ack at req+3; m1_rdata=0x1234; m0_rdata remains 0.
- M0 and M1 both requesting continuously with MAX_HOLD=4 → grant order M0,M0,M0,M0,M1,M0,M0,M0,M0,M1…; m1_ack count = 1 per 5 grants.
- M1 requests alone for 3 accesses while M0 idle, then M0 joins → M0 gets the next grant; hold_cnt starts at 0.
- Assert reset during WAIT of an M0 read → no m0_ack; all outputs 0 the cycle after reset; a subsequent M1 write completes normally in 2 cycles.
- RD_LAT=3 read of 0xA5A5 → m0_ack at req+5 with m0_rdata=0xA5A5; ram_re high only in ISSUE.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter and sequencer for the single-port system RAM.
// Master 0 (CPU) has priority. A bounded hold counter makes sure master 1 is
// served after at most MAX_HOLD back-to-back master 0 grants. Each access is
// sequenced through IDLE -> ISSUE -> (WAIT) -> ACK, and the requesting master
// receives a one-cycle ack pulse when its access completes.
module ram_arbiter #(
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_be,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_be,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_din,
  output logic        ram_we,
  output logic        ram_re,
  output logic        ram_be,
  input  logic [15:0] ram_dout,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;

  state_t      state;
  state_t      next_state;
  logic [3:0]  hold_cnt;
  logic [1:0]  lat_cnt;
  logic        cur_we;
  logic        cur_be;
  logic [15:0] cur_addr;
  logic [15:0] cur_wdata;
  logic [15:0] rdata0;
  logic [15:0] rdata1;

  logic any_req;
  logic hold_full;
  logic grant_m1;

  // Saturating increment of the M0 hold counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == HOLD_MAX) ? v : v + 4'd1;
  endfunction

  assign any_req   = m0_req | m1_req;
  assign hold_full = (hold_cnt == HOLD_MAX);
  // M1 wins when it is alone, or when M0 has used up its hold budget.
  assign grant_m1  = m1_req & (~m0_req | hold_full);

  assign ram_addr = cur_addr;
  assign ram_din  = cur_wdata;
  assign ram_be   = cur_be;
  assign m0_rdata = rdata0;
  assign m1_rdata = rdata1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode: writes skip WAIT, reads wait out the RAM latency.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ISSUE;
      ISSUE:   next_state = cur_we ? ACK : WAIT;
      WAIT:    if (lat_cnt == 2'd0) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes and acks are pure decodes of the state and the latched access.
  always_comb begin
    ram_we = 1'b0;
    ram_re = 1'b0;
    m0_ack = 1'b0;
    m1_ack = 1'b0;
    case (state)
      ISSUE: begin
        ram_we = cur_we;
        ram_re = ~cur_we;
      end
      ACK: begin
        m0_ack = (owner == OWN_M0);
        m1_ack = (owner == OWN_M1);
      end
      default: ;
    endcase
  end

  // Grant latching, hold/latency counters and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_NONE;
      hold_cnt  <= 4'd0;
      lat_cnt   <= 2'd0;
      cur_we    <= 1'b0;
      cur_be    <= 1'b0;
      cur_addr  <= 16'd0;
      cur_wdata <= 16'd0;
      rdata0    <= 16'd0;
      rdata1    <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            if (grant_m1) begin
              owner     <= OWN_M1;
              cur_we    <= m1_we;
              cur_be    <= m1_be;
              cur_addr  <= m1_addr;
              cur_wdata <= m1_wdata;
              hold_cnt  <= 4'd0;
            end else begin
              owner     <= OWN_M0;
              cur_we    <= m0_we;
              cur_be    <= m0_be;
              cur_addr  <= m0_addr;
              cur_wdata <= m0_wdata;
              hold_cnt  <= m1_req ? sat_inc(hold_cnt) : 4'd0;
            end
          end
        end
        ISSUE: begin
          if (!cur_we) lat_cnt <= LAT_INIT;
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            if (owner == OWN_M1) rdata1 <= ram_dout;
            else                 rdata0 <= ram_dout;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        ACK: begin
          owner <= OWN_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule
